// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard and sequencing controller for the five-stage RISC Toy core.
// Every cycle it decides whether the front end advances, whether IF/ID is
// flushed, whether ID/EX receives a bubble and whether the back end is frozen.
// It handles load-use hazards, taken-branch flushes, data-memory wait states
// guarded by a watchdog, and an orderly halt that drains older instructions.
// It also keeps saturating stall and flush statistics.
//
// Handshake: the MEM stage raises dmem_req while an access is outstanding.
// The access completes on a cycle where dmem_req and dmem_ready are both high.
// A cycle with dmem_req=1 and dmem_ready=0 is a freeze cycle.
//
// Parameters
//   TIMEOUT       max consecutive freeze cycles before mem_err (>= 2)
//   DRAIN_CYCLES  cycles needed to retire instructions older than a halt
//
// Ports
//   CLK, RST              clock; asynchronous active-high reset
//   ID_rs1/rs2, ID_uses_* source registers of the instruction in ID
//   ID_halt               instruction in ID is a halt
//   EX_mem_read, EX_rd    instruction in EX is a load / its destination
//   EX_branch_taken       branch/jump in EX resolved taken
//   dmem_req, dmem_ready  data-memory request / completion
//   PC_write, IF_ID_write front-end enables
//   IF_ID_flush           load a NOP into IF/ID
//   Stall                 zero ID/EX control fields (bubble)
//   pipe_hold             freeze ID/EX, EX/MEM and MEM/WB
//   halted                the core has stopped
//   mem_err               sticky watchdog error
//   stall_cycles          saturating count of non-halted cycles with PC_write=0
//   flush_count           saturating count of taken-branch flushes
//   state_dbg             current FSM state (debug visibility)
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT      = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_uses_rs1,
    input  logic        ID_uses_rs2,
    input  logic        ID_halt,
    input  logic        EX_mem_read,
    input  logic [4:0]  EX_rd,
    input  logic        EX_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        Stall,
    output logic        pipe_hold,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_HALTED   = 2'd3;

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_TOP   = WW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

    logic [1:0]    state, state_d;
    logic [WW-1:0] wait_cnt, wait_d;
    logic [DW-1:0] drain_cnt, drain_d;
    logic          err_set;
    logic          freeze;
    logic          loaduse;

    assign freeze  = dmem_req & ~dmem_ready;
    assign loaduse = EX_mem_read & (EX_rd != 5'd0) &
                     ((ID_uses_rs1 & (ID_rs1 == EX_rd)) |
                      (ID_uses_rs2 & (ID_rs2 == EX_rd)));

    assign state_dbg = state;

    always_comb begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b0;
        Stall       = 1'b0;
        pipe_hold   = 1'b0;
        halted      = 1'b0;
        state_d     = state;
        wait_d      = wait_cnt;
        drain_d     = drain_cnt;
        err_set     = 1'b0;
        // While RST is high every control stays low regardless of inputs.
        if (!RST) begin
            case (state)
                // RUN and MEM_WAIT share one priority list; MEM_WAIT only
                // differs in that it was entered by a freeze, and a release
                // from it falls straight through to the RUN decisions.
                S_RUN, S_MEM_WAIT: begin
                    if (freeze) begin
                        pipe_hold = 1'b1;
                        if (wait_cnt == WAIT_TOP) begin
                            err_set = 1'b1;
                            state_d = S_HALTED;
                        end else begin
                            wait_d  = wait_cnt + WW'(1);
                            state_d = S_MEM_WAIT;
                        end
                    end else begin
                        wait_d  = '0;
                        state_d = S_RUN;
                        if (EX_branch_taken) begin
                            // Redirect: PC loads the target, IF/ID and ID/EX
                            // both lose their wrong-path instruction.
                            PC_write    = 1'b1;
                            IF_ID_write = 1'b1;
                            IF_ID_flush = 1'b1;
                            Stall       = 1'b1;
                        end else if (loaduse) begin
                            Stall = 1'b1;
                        end else if (ID_halt) begin
                            Stall   = 1'b1;
                            drain_d = DRAIN_INIT;
                            state_d = S_DRAIN;
                        end else begin
                            PC_write    = 1'b1;
                            IF_ID_write = 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    Stall = 1'b1;
                    if (freeze) begin
                        pipe_hold = 1'b1;
                        if (wait_cnt == WAIT_TOP) begin
                            err_set = 1'b1;
                            state_d = S_HALTED;
                        end else begin
                            wait_d = wait_cnt + WW'(1);
                        end
                    end else begin
                        wait_d = '0;
                        if (drain_cnt == '0) state_d = S_HALTED;
                        else                 drain_d = drain_cnt - DW'(1);
                    end
                end
                S_HALTED: begin
                    Stall  = 1'b1;
                    halted = 1'b1;
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_RUN;
            wait_cnt     <= '0;
            drain_cnt    <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_d;
            drain_cnt <= drain_d;
            if (err_set) mem_err <= 1'b1;
            if (!PC_write && state != S_HALTED && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (IF_ID_flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed scenarios plus randomized traffic against a behavioural model of
// the hazard controller. The model tracks the core as "halted / draining with
// N cycles left / running with K consecutive freeze cycles" and derives every
// control and counter from the rules directly.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT      = 16;
    localparam int DRAIN_CYCLES = 3;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [4:0]  ID_rs1, ID_rs2, EX_rd;
    logic        ID_uses_rs1, ID_uses_rs2, ID_halt;
    logic        EX_mem_read, EX_branch_taken, dmem_req, dmem_ready;
    logic        PC_write, IF_ID_write, IF_ID_flush, Stall, pipe_hold, halted;
    logic        mem_err;
    logic [15:0] stall_cycles, flush_count;
    logic [1:0]  state_dbg;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .CLK(CLK), .RST(RST),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_halt(ID_halt), .EX_mem_read(EX_mem_read), .EX_rd(EX_rd),
        .EX_branch_taken(EX_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .Stall(Stall), .pipe_hold(pipe_hold),
        .halted(halted), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {PC_write, IF_ID_write, IF_ID_flush, Stall, pipe_hold, halted}
    function automatic logic [5:0] ctl_now();
        return {PC_write, IF_ID_write, IF_ID_flush, Stall, pipe_hold, halted};
    endfunction

    // ---------------- reference model ----------------
    bit m_halted;
    bit m_draining;
    int m_drain_left;   // drain cycles still to run, including the current one
    int m_freeze_run;   // consecutive freeze cycles seen so far
    bit m_err;
    int m_stalls;
    int m_flushes;

    function automatic int sat16(input int x);
        return (x < 65535) ? x + 1 : x;
    endfunction

    task automatic model_clear();
        m_halted = 0; m_draining = 0; m_drain_left = 0;
        m_freeze_run = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then
    // return 1 time unit after the rising edge so callers can drive inputs.
    task automatic step();
        bit fz, lu, pc, ifid, fl, st, hd, hl;
        @(negedge CLK);
        if (RST) model_clear();
        check_val("stall_cycles", {16'd0, stall_cycles}, m_stalls);
        check_val("flush_count", {16'd0, flush_count}, m_flushes);
        check_val("mem_err", {31'd0, mem_err}, {31'd0, m_err});
        pc = 0; ifid = 0; fl = 0; st = 0; hd = 0; hl = 0;
        if (!RST) begin
            fz = dmem_req && !dmem_ready;
            lu = EX_mem_read && EX_rd != 0 &&
                 ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
            if (m_halted) begin
                st = 1; hl = 1;
            end else if (m_draining) begin
                st = 1; hd = fz;
                m_stalls = sat16(m_stalls);
                if (fz) begin
                    m_freeze_run++;
                    if (m_freeze_run == TIMEOUT) begin m_err = 1; m_halted = 1; end
                end else begin
                    m_freeze_run = 0;
                    m_drain_left--;
                    if (m_drain_left == 0) m_halted = 1;
                end
            end else if (fz) begin
                hd = 1;
                m_stalls = sat16(m_stalls);
                m_freeze_run++;
                if (m_freeze_run == TIMEOUT) begin m_err = 1; m_halted = 1; end
            end else begin
                m_freeze_run = 0;
                if (EX_branch_taken) begin
                    pc = 1; ifid = 1; fl = 1; st = 1;
                    m_flushes = sat16(m_flushes);
                end else if (lu) begin
                    st = 1; m_stalls = sat16(m_stalls);
                end else if (ID_halt) begin
                    st = 1; m_stalls = sat16(m_stalls);
                    m_draining = 1; m_drain_left = DRAIN_CYCLES;
                end else begin
                    pc = 1; ifid = 1;
                end
            end
        end
        check_val("ctl", {26'd0, ctl_now()}, {26'd0, pc, ifid, fl, st, hd, hl});
        @(posedge CLK);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_in();
        ID_rs1 = 0; ID_rs2 = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0; ID_halt = 0;
        EX_mem_read = 0; EX_rd = 0; EX_branch_taken = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_in();
        #1;
        check_val("rst_ctl", {26'd0, ctl_now()}, 32'd0);
        step();
        RST = 1'b0;
    endtask

    task automatic rand_in();
        ID_rs1 = 5'($urandom_range(0, 3));
        ID_rs2 = 5'($urandom_range(0, 3));
        EX_rd  = 5'($urandom_range(0, 3));
        ID_uses_rs1     = ($urandom_range(0, 1) == 1);
        ID_uses_rs2     = ($urandom_range(0, 1) == 1);
        EX_mem_read     = ($urandom_range(0, 9) < 4);
        EX_branch_taken = ($urandom_range(0, 9) == 0);
        ID_halt         = ($urandom_range(0, 19) == 0);
        dmem_req        = ($urandom_range(0, 9) < 3);
        dmem_ready      = ($urandom_range(0, 1) == 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n_hold;
        int stuck;
        RST = 1'b1;
        clear_in();
        model_clear();

        // Load-use: one bubble, then normal; r0 never creates a hazard.
        do_reset();
        EX_mem_read = 1; EX_rd = 5; ID_rs2 = 5; ID_uses_rs2 = 1;
        #1 check_val("lu_ctl", {26'd0, ctl_now()}, 32'b000100);
        step();
        check_val("lu_stall_cnt", {16'd0, stall_cycles}, 32'd1);
        clear_in();
        #1 check_val("lu_after", {26'd0, ctl_now()}, 32'b110000);
        step();
        EX_mem_read = 1; EX_rd = 0; ID_rs2 = 0; ID_uses_rs2 = 1;
        #1 check_val("lu_r0", {26'd0, ctl_now()}, 32'b110000);
        step();
        check_val("lu_r0_cnt", {16'd0, stall_cycles}, 32'd1);

        // Branch beats load-use and halt.
        do_reset();
        EX_branch_taken = 1; ID_halt = 1;
        EX_mem_read = 1; EX_rd = 7; ID_rs1 = 7; ID_uses_rs1 = 1;
        #1 check_val("br_ctl", {26'd0, ctl_now()}, 32'b111100);
        step();
        check_val("br_flush_cnt", {16'd0, flush_count}, 32'd1);
        clear_in();
        #1 check_val("br_still_run", {26'd0, ctl_now()}, 32'b110000);
        step();

        // Four freeze cycles then completion.
        do_reset();
        n_hold = 0;
        for (int i = 0; i < 5; i++) begin
            dmem_req = 1; dmem_ready = (i == 4);
            #1 if (pipe_hold) n_hold++;
            step();
        end
        clear_in();
        check_val("frz_hold_cycles", n_hold, 32'd4);
        check_val("frz_stall_cnt", {16'd0, stall_cycles}, 32'd4);
        check_val("frz_mem_err", {31'd0, mem_err}, 32'd0);
        #1 check_val("frz_back_run", {26'd0, ctl_now()}, 32'b110000);
        step();

        // Watchdog expiry after TIMEOUT freeze cycles.
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (i == TIMEOUT - 1) check_val("wd_not_yet", {31'd0, halted}, 32'd0);
            step();
        end
        check_val("wd_halted", {31'd0, halted}, 32'd1);
        check_val("wd_mem_err", {31'd0, mem_err}, 32'd1);
        step();

        // Halt and drain without freeze.
        do_reset();
        ID_halt = 1;
        step();
        ID_halt = 0;
        step(); step();
        check_val("drain_not_yet", {31'd0, halted}, 32'd0);
        step();
        check_val("drain_halted", {31'd0, halted}, 32'd1);
        check_val("drain_stall_cnt", {16'd0, stall_cycles}, 32'd4);

        // Halt and drain with a two-cycle freeze inside DRAIN.
        do_reset();
        ID_halt = 1;
        step();
        ID_halt = 0;
        step();
        dmem_req = 1; dmem_ready = 0;
        step(); step();
        clear_in();
        step();
        check_val("drain_frz_not_yet", {31'd0, halted}, 32'd0);
        step();
        check_val("drain_frz_halted", {31'd0, halted}, 32'd1);

        // Reset in the middle of DRAIN.
        do_reset();
        ID_halt = 1;
        step();
        ID_halt = 0;
        step();
        do_reset();
        #1 check_val("mid_drain_rst_run", {26'd0, ctl_now()}, 32'b110000);
        check_val("mid_drain_rst_cnt", {16'd0, stall_cycles}, 32'd0);
        step();

        // Randomized traffic against the model.
        stuck = 0;
        for (int c = 0; c < 2000; c++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rand_in();
                if (stuck > 0) begin
                    dmem_req = 1; dmem_ready = 0; stuck--;
                end else if ($urandom_range(0, 99) == 0) begin
                    stuck = $urandom_range(8, 20);
                end
                step();
            end
        end

        // flush_count saturation, then reset clears it.
        do_reset();
        EX_branch_taken = 1;
        for (int i = 0; i < 65535; i++) step();
        check_val("flush_sat_reach", {16'd0, flush_count}, 32'h0000FFFF);
        step();
        check_val("flush_sat_hold", {16'd0, flush_count}, 32'h0000FFFF);
        do_reset();
        check_val("flush_after_rst", {16'd0, flush_count}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
